// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit.
// A shared 64-bit {r_hi, r_lo} register does two jobs. For a multiply it runs a
// shift-add on the operand magnitudes. For a divide it runs a restoring division.
// Sign correction is applied once, in DONE.
// Divide-by-zero and signed overflow take a fast path that skips CALC.
module muldiv_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_operand1,
  input  logic [31:0] i_operand2,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result
);

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [2:0] F_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [2:0]  r_funct3;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_m;
  logic [5:0]  r_cnt;
  logic        r_neg;
  logic        r_neg_rem;
  logic        r_fast;
  logic [31:0] r_fast_val;
  logic        r_done;
  logic [31:0] r_result;

  logic        w_accept;
  logic        w_sign1;
  logic        w_sign2;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_fast;
  logic [31:0] w_fast_val;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [31:0] w_div_sub;
  logic [31:0] w_hi_step;
  logic [31:0] w_lo_step;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_final;

  // A start is taken only in IDLE. The cycle in which done is high counts as the
  // tail of the previous operation. The earliest back-to-back start is therefore
  // the cycle after done.
  assign w_accept = (r_state == S_IDLE) && i_start && !r_done;

  // Launch-time decode: signedness, magnitudes, and fast-path detection.
  always_comb begin
    w_sign1    = i_operand1[31] && (i_funct3 == F_MULH || i_funct3 == F_MULHSU ||
                                    i_funct3 == F_DIV  || i_funct3 == F_REM);
    w_sign2    = i_operand2[31] && (i_funct3 == F_MULH || i_funct3 == F_DIV ||
                                    i_funct3 == F_REM);
    w_mag1     = w_sign1 ? (32'd0 - i_operand1) : i_operand1;
    w_mag2     = w_sign2 ? (32'd0 - i_operand2) : i_operand2;
    w_div_zero = i_funct3[2] && (i_operand2 == 32'd0);
    w_div_ovf  = (i_funct3 == F_DIV || i_funct3 == F_REM) &&
                 (i_operand1 == 32'h8000_0000) && (i_operand2 == 32'hFFFF_FFFF);
    w_fast     = w_div_zero || w_div_ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU.
    if (w_div_zero) begin
      w_fast_val = i_funct3[1] ? i_operand1 : 32'hFFFF_FFFF;
    end else begin
      w_fast_val = i_funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One radix-2 step: either shift-add (multiply) or compare-subtract (divide).
  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : 33'd0);
    w_div_shift = {r_hi, r_lo[31]};
    w_div_ge    = (w_div_shift >= {1'b0, r_m});
    // The partial remainder stays below twice the divisor, so the difference fits in 32 bits.
    w_div_sub   = w_div_shift[31:0] - r_m;
    if (r_funct3[2]) begin
      w_hi_step = w_div_ge ? w_div_sub : w_div_shift[31:0];
      w_lo_step = {r_lo[30:0], w_div_ge};
    end else begin
      w_hi_step = w_mul_sum[32:1];
      w_lo_step = {w_mul_sum[0], r_lo[31:1]};
    end
  end

  // Sign correction and result selection applied in DONE.
  always_comb begin
    w_prod_fix = r_neg ? (64'd0 - {r_hi, r_lo}) : {r_hi, r_lo};
    w_quo_fix  = r_neg ? (32'd0 - r_lo) : r_lo;
    w_rem_fix  = r_neg_rem ? (32'd0 - r_hi) : r_hi;
    case (r_funct3)
      F_MUL:                     w_final = w_prod_fix[31:0];
      F_MULH, F_MULHSU, F_MULHU: w_final = w_prod_fix[63:32];
      F_DIV, F_DIVU:             w_final = w_quo_fix;
      default:                   w_final = w_rem_fix;
    endcase
    if (r_fast) begin
      w_final = r_fast_val;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_fast ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == 6'd31) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs: busy covers CALC and DONE; done and result come from registers.
  always_comb begin
    o_busy   = (r_state != S_IDLE);
    o_done   = r_done;
    o_result = r_result;
  end

  // Datapath: latch at launch, iterate in CALC, load result in DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_funct3   <= 3'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_m        <= 32'd0;
      r_cnt      <= 6'd0;
      r_neg      <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_fast     <= 1'b0;
      r_fast_val <= 32'd0;
      r_done     <= 1'b0;
      r_result   <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_funct3   <= i_funct3;
            r_neg      <= w_sign1 ^ w_sign2;
            r_neg_rem  <= w_sign1;
            r_cnt      <= 6'd0;
            r_fast     <= w_fast;
            r_fast_val <= w_fast_val;
            r_hi       <= 32'd0;
            // Divide shifts the dividend out of r_lo and subtracts the divisor.
            // Multiply shifts the multiplier out of r_lo and adds the multiplicand.
            if (i_funct3[2]) begin
              r_lo <= w_mag1;
              r_m  <= w_mag2;
            end else begin
              r_lo <= w_mag2;
              r_m  <= w_mag1;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_step;
          r_lo  <= w_lo_step;
          r_cnt <= r_cnt + 6'd1;
        end
        S_DONE: begin
          r_result <= w_final;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit.
// The checks cover results, latency, busy/done timing, back-to-back issue and abort on reset.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_vec;
  int          n_mis;
  logic [31:0] last_res;

  muldiv_unit dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_funct3   (funct3),
    .i_operand1 (operand1),
    .i_operand2 (operand2),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    t  = 64'd0;
    case (f)
      3'd0: begin t = sa * sb; return t[31:0]; end
      3'd1: begin t = sa * sb; return t[63:32]; end
      3'd2: begin t = sa * ub; return t[63:32]; end
      3'd3: begin t = {32'd0, a} * {32'd0, b}; return t[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        t = sa / sb; return t[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        t = sa % sb; return t[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one operation with a single-cycle start, then scramble the inputs.
  // The task then checks latency, busy, result hold, the result itself and done width.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_res;
    int          exp_lat;
    int          n;
    logic        busy_ok;
    logic        hold_ok;
    exp_res = ref_op(f, a, b);
    exp_lat = ref_lat(f, a, b);
    @(negedge clk);
    start = 1'b1; funct3 = f; operand1 = a; operand2 = b;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); operand1 = $urandom; operand2 = $urandom;
    busy_ok = (busy === 1'b1) && (done === 1'b0);
    hold_ok = (result === last_res);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (done !== 1'b1) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (result !== last_res) hold_ok = 1'b0;
      end
    end
    check_val("latency", 64'(n), 64'(exp_lat));
    check_val("result", {32'd0, result}, {32'd0, exp_res});
    check_val("busy_span", {63'd0, busy_ok}, 64'd1);
    check_val("result_hold", {63'd0, hold_ok}, 64'd1);
    check_val("busy_at_done", {63'd0, busy}, 64'd0);
    $display("op f3=%0d a=%h b=%h -> result=%h (exp %h) latency=%0d", f, a, b, result, exp_res, n);
    @(posedge clk); #1;
    check_val("done_width", {63'd0, done}, 64'd0);
    last_res = exp_res;
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;
    n_vec = 0; n_mis = 0; last_res = 32'd0;
    rst = 1'b1; start = 1'b0; funct3 = 3'd0; operand1 = 32'd0; operand2 = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    check_val("rst_result", {32'd0, result}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Directed cases
    do_op(3'd0, 32'd7,          32'hFFFF_FFFD);
    do_op(3'd1, 32'h8000_0000,  32'h8000_0000);
    do_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    do_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    do_op(3'd4, 32'hFFFF_FFF9,  32'd2);
    do_op(3'd6, 32'hFFFF_FFF9,  32'd2);
    do_op(3'd5, 32'd100,        32'd7);
    do_op(3'd7, 32'd100,        32'd7);
    do_op(3'd4, 32'd5,          32'd0);
    do_op(3'd6, 32'd5,          32'd0);
    do_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
    do_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF);
    do_op(3'd5, 32'h8000_0000,  32'hFFFF_FFFF);

    // Randomized cases with boundary operands mixed in
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = 32'($urandom_range(1, 15));
      do_op(f, a, b);
    end

    // Start held high with operands changing every cycle
    begin
      int          e;
      int          next_free;
      int          done_edge;
      int          n_acc;
      int          n_dn;
      logic        pending;
      logic [31:0] exp_b;
      e = 0; next_free = 0; done_edge = 0; n_acc = 0; n_dn = 0; pending = 1'b0; exp_b = 32'd0;
      while (e < 200) begin
        @(negedge clk);
        start = (e < 150);
        funct3 = 3'($urandom_range(0, 7));
        operand1 = $urandom;
        operand2 = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
        if (start && e >= next_free) begin
          exp_b     = ref_op(funct3, operand1, operand2);
          done_edge = e + ref_lat(funct3, operand1, operand2);
          next_free = done_edge + 2;
          pending   = 1'b1;
          n_acc++;
        end
        @(posedge clk); #1;
        if (done === 1'b1) begin
          check_val("b2b_spurious_done", {63'd0, pending}, 64'd1);
          if (pending) begin
            check_val("b2b_done_edge", 64'(e), 64'(done_edge));
            check_val("b2b_result", {32'd0, result}, {32'd0, exp_b});
            $display("b2b done at edge %0d result=%h (exp %h)", e, result, exp_b);
            last_res = exp_b;
            pending = 1'b0;
            n_dn++;
          end
        end else if (pending && e >= done_edge) begin
          check_val("b2b_done_edge", 64'd0, 64'(done_edge));
          pending = 1'b0;
        end
        e++;
      end
      start = 1'b0;
      check_val("b2b_done_count", 64'(n_dn), 64'(n_acc));
    end

    // Abort a DIVU with reset at cycle 10, then confirm recovery
    begin
      logic saw_done;
      @(negedge clk);
      start = 1'b1; funct3 = 3'd5; operand1 = 32'd100; operand2 = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check_val("abort_busy", {63'd0, busy}, 64'd0);
      check_val("abort_done", {63'd0, done}, 64'd0);
      check_val("abort_result", {32'd0, result}, 64'd0);
      $display("reset abort: busy=%b done=%b result=%h", busy, done, result);
      @(negedge clk); rst = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
        @(posedge clk); #1;
        if (done === 1'b1) saw_done = 1'b1;
      end
      check_val("abort_no_done", {63'd0, saw_done}, 64'd0);
      last_res = 32'd0;
      do_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
